// File: rtl/axi_return_writer_if.sv
// AXI4 write-only master bundle (AW/W/B) used by axi_return_writer.
interface axi_return_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_return_writer.sv
// Packs IN_WIDTH results into MEM_DATA_WIDTH words and writes them to DDR as AXI4 INCR bursts.
// Define RW_LANE_SWAP_EN to reverse the IN_WIDTH lanes of every wdata word.
module axi_return_writer #(
  parameter int IN_WIDTH        = 128,
  parameter int MEM_DATA_WIDTH  = 512,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int BURST_LEN       = 64,
  parameter int FIFO_DEPTH_LOG2 = 9,
  parameter int MAX_OUTST       = 4
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      job_start,
  input  logic [MEM_ADDR_WIDTH-1:0] job_addr,
  input  logic [23:0]               job_beats,
  output logic                      job_busy,
  output logic                      job_done,
  output logic                      job_err,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  axi_return_writer_if.master       m00_axi
);

  localparam int RATIO       = MEM_DATA_WIDTH / IN_WIDTH;
  localparam int BW          = MEM_DATA_WIDTH / 8;
  localparam int LANE_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH       = 1 << FIFO_DEPTH_LOG2;
  localparam int CW          = FIFO_DEPTH_LOG2 + 1;
  localparam int LEN_W       = $clog2(BURST_LEN + 1);
  localparam int OW          = $clog2(MAX_OUTST + 1);
  localparam int QW          = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int BURST_BYTES = BURST_LEN * BW;
  localparam int AWSIZE      = $clog2(BW);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ISSUE, S_DRAIN} aw_state_e;

  aw_state_e                   state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        awvalid_q, awvalid_d;
  logic [MEM_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]                  awlen_q, awlen_d;
  logic [LEN_W-1:0]            issue_len_q, issue_len_d;
  logic [23:0]                 beats_left_q, beats_left_d;
  logic [31:0]                 total_words_q, total_words_d;
  logic [31:0]                 in_words_q, in_words_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [MEM_DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]               reserved_q, reserved_d;
  logic [OW-1:0]               outst_q, outst_d;
  logic [LEN_W-1:0]            bq_q [MAX_OUTST];
  logic [LEN_W-1:0]            bq_d [MAX_OUTST];
  logic [QW-1:0]               bq_wr_q, bq_wr_d;
  logic [QW-1:0]               bq_rd_q, bq_rd_d;
  logic [OW-1:0]               bq_cnt_q, bq_cnt_d;
  logic [LEN_W-1:0]            beat_cnt_q, beat_cnt_d;

  logic [MEM_DATA_WIDTH-1:0]   fifo_mem [DEPTH];
  logic [MEM_DATA_WIDTH-1:0]   packed_word;
  logic [MEM_DATA_WIDTH-1:0]   rd_word;
  logic [CW-1:0]               fifo_free;
  logic [LEN_W-1:0]            next_len;
  logic [LEN_W-1:0]            head_len;
  logic                        in_fire, in_store, fifo_push;
  logic                        wvalid, wlast, w_fire, aw_fire, bready, b_fire;

  assign fifo_free = CW'(DEPTH) - fifo_cnt_q;
  assign in_ready  = busy_q && (fifo_free >= CW'(2));
  assign in_fire   = in_valid && in_ready;
  // Words past the job's length are still handshaken so the producer never stalls on them.
  assign in_store  = in_fire && (in_words_q < total_words_q);
  assign fifo_push = in_store && (lane_q == LANE_W'(RATIO - 1));

  assign head_len = bq_q[bq_rd_q];
  assign wvalid   = (bq_cnt_q != '0) && (fifo_cnt_q != '0);
  assign wlast    = (beat_cnt_q == head_len - LEN_W'(1));
  assign w_fire   = wvalid && m00_axi.wready;
  assign aw_fire  = awvalid_q && m00_axi.awready;
  assign bready   = (outst_q != '0);
  assign b_fire   = m00_axi.bvalid && bready;
  assign next_len = (beats_left_q >= 24'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(beats_left_q);
  assign rd_word  = fifo_mem[rd_ptr_q];

  always_comb begin
    packed_word = pack_q;
    packed_word[lane_q*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge system_clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= packed_word;
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    issue_len_d   = issue_len_q;
    beats_left_d  = beats_left_q;
    total_words_d = total_words_q;
    in_words_d    = in_words_q;
    lane_d        = lane_q;
    pack_d        = pack_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    reserved_d    = reserved_q;
    outst_d       = outst_q;
    bq_d          = bq_q;
    bq_wr_d       = bq_wr_q;
    bq_rd_d       = bq_rd_q;
    bq_cnt_d      = bq_cnt_q;
    beat_cnt_d    = beat_cnt_q;

    if (in_store) begin
      in_words_d = in_words_q + 32'd1;
      pack_d     = packed_word;
      lane_d     = (lane_q == LANE_W'(RATIO - 1)) ? '0 : lane_q + LANE_W'(1);
    end

    if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_fire)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({fifo_push, w_fire})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    reserved_d = reserved_q + (aw_fire ? CW'(issue_len_q) : '0) - (w_fire ? CW'(1) : '0);

    case ({aw_fire, b_fire})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    if (b_fire && (m00_axi.bresp != 2'b00)) err_d = 1'b1;

    // The burst-length queue tells the W side where each wlast falls.
    if (aw_fire) begin
      bq_d[bq_wr_q] = issue_len_q;
      bq_wr_d       = bq_wr_q + 1'b1;
    end
    if (w_fire) begin
      beat_cnt_d = wlast ? '0 : beat_cnt_q + LEN_W'(1);
      if (wlast) bq_rd_d = bq_rd_q + 1'b1;
    end
    case ({aw_fire, w_fire && wlast})
      2'b10:   bq_cnt_d = bq_cnt_q + OW'(1);
      2'b01:   bq_cnt_d = bq_cnt_q - OW'(1);
      default: bq_cnt_d = bq_cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          err_d = 1'b0;
          if (job_beats != 24'd0) begin
            state_d       = S_ARM;
            busy_d        = 1'b1;
            awaddr_d      = job_addr;
            beats_left_d  = job_beats;
            total_words_d = 32'(job_beats) * 32'(RATIO);
            in_words_d    = '0;
            lane_d        = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fifo_cnt_d    = '0;
            reserved_d    = '0;
            outst_d       = '0;
            bq_wr_d       = '0;
            bq_rd_d       = '0;
            bq_cnt_d      = '0;
            beat_cnt_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        // A burst is only announced once all of its data is already sitting in the FIFO.
        if (beats_left_q == 24'd0) begin
          state_d = S_DRAIN;
        end else if ((fifo_cnt_q - reserved_q >= CW'(next_len)) && (outst_q < OW'(MAX_OUTST))) begin
          state_d     = S_ISSUE;
          awvalid_d   = 1'b1;
          awlen_d     = 8'(next_len - LEN_W'(1));
          issue_len_d = next_len;
        end
      end
      S_ISSUE: begin
        if (aw_fire) begin
          state_d      = S_ARM;
          awvalid_d    = 1'b0;
          awaddr_d     = awaddr_q + MEM_ADDR_WIDTH'(BURST_BYTES);
          beats_left_d = beats_left_q - 24'(issue_len_q);
        end
      end
      S_DRAIN: begin
        if ((outst_q == '0) && (bq_cnt_q == '0)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      issue_len_q   <= '0;
      beats_left_q  <= '0;
      total_words_q <= '0;
      in_words_q    <= '0;
      lane_q        <= '0;
      pack_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      reserved_q    <= '0;
      outst_q       <= '0;
      bq_q          <= '{default: '0};
      bq_wr_q       <= '0;
      bq_rd_q       <= '0;
      bq_cnt_q      <= '0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      issue_len_q   <= issue_len_d;
      beats_left_q  <= beats_left_d;
      total_words_q <= total_words_d;
      in_words_q    <= in_words_d;
      lane_q        <= lane_d;
      pack_q        <= pack_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      reserved_q    <= reserved_d;
      outst_q       <= outst_d;
      bq_q          <= bq_d;
      bq_wr_q       <= bq_wr_d;
      bq_rd_q       <= bq_rd_d;
      bq_cnt_q      <= bq_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

`ifdef RW_LANE_SWAP_EN
  logic [MEM_DATA_WIDTH-1:0] swapped_word;
  always_comb begin
    swapped_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      swapped_word[k*IN_WIDTH +: IN_WIDTH] = rd_word[(RATIO-1-k)*IN_WIDTH +: IN_WIDTH];
    end
  end
  assign m00_axi.wdata = swapped_word;
`else
  assign m00_axi.wdata = rd_word;
`endif

  assign job_busy        = busy_q;
  assign job_done        = done_q;
  assign job_err         = err_q;
  assign m00_axi.awaddr  = awaddr_q;
  assign m00_axi.awlen   = awlen_q;
  assign m00_axi.awsize  = 3'(AWSIZE);
  assign m00_axi.awburst = 2'b01;
  assign m00_axi.awlock  = 1'b0;
  assign m00_axi.awcache = 4'd0;
  assign m00_axi.awprot  = 3'd0;
  assign m00_axi.awqos   = 4'd0;
  assign m00_axi.awvalid = awvalid_q;
  assign m00_axi.wstrb   = '1;
  assign m00_axi.wlast   = wvalid && wlast;
  assign m00_axi.wvalid  = wvalid;
  assign m00_axi.bready  = bready;

endmodule

// File: tb/tb_axi_return_writer.sv
// Scoreboard bench for axi_return_writer: random data, queue-based AXI reference, randomized slave.
module tb_axi_return_writer;

  localparam int IW    = 128;
  localparam int DW    = 512;
  localparam int RATIO = DW / IW;
  localparam int BLEN  = 64;

  logic            clk;
  logic            rst_n;
  logic            job_start;
  logic [31:0]     job_addr;
  logic [23:0]     job_beats;
  logic            job_busy;
  logic            job_done;
  logic            job_err;
  logic [IW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;

  axi_return_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) axi ();

  axi_return_writer dut (
    .system_clk (clk),
    .rst_n      (rst_n),
    .job_start  (job_start),
    .job_addr   (job_addr),
    .job_beats  (job_beats),
    .job_busy   (job_busy),
    .job_done   (job_done),
    .job_err    (job_err),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .m00_axi    (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0]   aw_exp_addr [$];
  int            aw_exp_len  [$];
  logic [DW-1:0] w_exp_data  [$];
  bit            w_exp_last  [$];
  bit            done_exp    [$];
  logic [IW-1:0] in_q        [$];

  int job_id    = 0;
  int err_burst = -1;
  bit b_hold    = 1'b0;
  bit rand_mode = 1'b0;

  int aw_seen    = 0;
  int wlast_seen = 0;
  int w_beats    = 0;
  int done_cnt   = 0;
  int outst_mon  = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: burst split, packing and wlast placement derived from the job length alone.
  task automatic prepJob(input logic [31:0] addr, input int beats);
    logic [DW-1:0] word;
    logic [IW-1:0] lw;
    int nb;
    job_id++;
    nb = (beats + BLEN - 1) / BLEN;
    for (int i = 0; i < nb; i++) begin
      aw_exp_addr.push_back(addr + 32'(i * 4096));
      aw_exp_len.push_back(((beats - i*BLEN) >= BLEN) ? BLEN - 1 : beats - i*BLEN - 1);
    end
    for (int b = 0; b < beats; b++) begin
      word = '0;
      for (int l = 0; l < RATIO; l++) begin
        lw = {$urandom, $urandom, $urandom, $urandom};
        in_q.push_back(lw);
`ifdef RW_LANE_SWAP_EN
        word[(RATIO-1-l)*IW +: IW] = lw;
`else
        word[l*IW +: IW] = lw;
`endif
      end
      w_exp_data.push_back(word);
      w_exp_last.push_back(((b % BLEN) == BLEN - 1) || (b == beats - 1));
    end
    done_exp.push_back((err_burst >= 0) && (err_burst < nb));
  endtask

  task automatic pulseStart(input logic [31:0] addr, input int beats);
    @(posedge clk); #1;
    job_start = 1'b1;
    job_addr  = addr;
    job_beats = 24'(beats);
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic applyStimulus(input bit gaps, input int max_words);
    int sent = 0;
    int guard = 0;
    while (in_q.size() > 0 && sent < max_words && guard < 20000) begin
      @(posedge clk); #1;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_q[0];
      @(negedge clk);
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        sent++;
      end
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (guard >= 20000) checkOutput("input_drive_timeout", 512'(guard), 512'(0));
  endtask

  task automatic waitDone(input string name, input int target, input int bursts);
    int guard = 0;
    while (done_cnt < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_done_seen"}, 512'(done_cnt >= target), 512'(1));
    repeat (5) @(negedge clk);
    checkOutput({name, "_done_once"}, 512'(done_cnt), 512'(target));
    checkOutput({name, "_busy_after"}, 512'(job_busy), 512'(0));
    checkOutput({name, "_bursts"}, 512'(aw_seen), 512'(bursts));
    checkOutput({name, "_aw_left"}, 512'(aw_exp_addr.size()), 512'(0));
    checkOutput({name, "_w_left"}, 512'(w_exp_data.size()), 512'(0));
  endtask

  // AXI slave ready generation.
  initial begin
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    forever begin
      @(posedge clk); #1;
      axi.awready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi.wready  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // AXI slave write responses: one B per burst whose address and last beat were both seen.
  initial begin
    int b_cnt = 0;
    int drv_job = 0;
    int guard;
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (drv_job != job_id) begin
        b_cnt = 0;
        drv_job = job_id;
      end
      if (rst_n && !b_hold && b_cnt < aw_seen && b_cnt < wlast_seen) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        guard = 0;
        @(negedge clk);
        while (!axi.bready && rst_n && guard < 1000) begin
          @(negedge clk);
          guard++;
        end
        @(posedge clk); #1;
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        b_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake or signals done.
  initial begin
    int mon_job = 0;
    logic [DW-1:0] ed;
    bit el;
    forever begin
      @(negedge clk);
      if (!rst_n || mon_job != job_id) begin
        aw_seen = 0;
        wlast_seen = 0;
        w_beats = 0;
        outst_mon = 0;
        mon_job = job_id;
      end
      if (rst_n) begin
        if (axi.bvalid && axi.bready) outst_mon--;
        if (axi.awvalid && axi.awready) begin
          if (aw_exp_addr.size() == 0) begin
            checkOutput("aw_unexpected", 512'(axi.awaddr), 512'(0));
          end else begin
            checkOutput("awaddr", 512'(axi.awaddr), 512'(aw_exp_addr.pop_front()));
            checkOutput("awlen", 512'(axi.awlen), 512'(aw_exp_len.pop_front()));
          end
          checkOutput("awsize", 512'(axi.awsize), 512'(6));
          checkOutput("awburst", 512'(axi.awburst), 512'(1));
          aw_seen++;
          outst_mon++;
          checkOutput("outstanding_limit", 512'(outst_mon <= 4), 512'(1));
        end
        if (axi.wvalid && axi.wready) begin
          if (w_exp_data.size() == 0) begin
            checkOutput("w_unexpected", axi.wdata, '0);
          end else begin
            ed = w_exp_data.pop_front();
            el = w_exp_last.pop_front();
            checkOutput("wdata", axi.wdata, ed);
            checkOutput("wlast", 512'(axi.wlast), 512'(el));
          end
          w_beats++;
          if (axi.wlast) wlast_seen++;
        end
        if (job_done) begin
          if (done_exp.size() == 0) checkOutput("done_unexpected", 512'(1), 512'(0));
          else checkOutput("job_err_at_done", 512'(job_err), 512'(done_exp.pop_front()));
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    job_start = 1'b0;
    job_addr = '0;
    job_beats = '0;
    in_data = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 512'(job_busy), 512'(0));
    checkOutput("rst_done", 512'(job_done), 512'(0));
    checkOutput("rst_err", 512'(job_err), 512'(0));
    checkOutput("rst_in_ready", 512'(in_ready), 512'(0));
    checkOutput("rst_awvalid", 512'(axi.awvalid), 512'(0));
    checkOutput("rst_wvalid", 512'(axi.wvalid), 512'(0));
    checkOutput("rst_bready", 512'(axi.bready), 512'(0));
    checkOutput("rst_awaddr", 512'(axi.awaddr), 512'(0));
    checkOutput("rst_awsize", 512'(axi.awsize), 512'(6));
    checkOutput("rst_awburst", 512'(axi.awburst), 512'(1));
    rst_n = 1'b1;

    $display("[TB] job A: 128 beats @0x1000, second start while busy");
    prepJob(32'h1000, 128);
    pulseStart(32'h1000, 128);
    @(negedge clk);
    checkOutput("jobA_busy", 512'(job_busy), 512'(1));
    pulseStart(32'h9000, 5);
    applyStimulus(1'b0, 1 << 30);
    waitDone("jobA", 1, 2);

    $display("[TB] job B: 70 beats, short final burst");
    prepJob(32'h4000, 70);
    pulseStart(32'h4000, 70);
    applyStimulus(1'b0, 1 << 30);
    waitDone("jobB", 2, 2);

    $display("[TB] job C: 512 beats with B responses withheld");
    b_hold = 1'b1;
    prepJob(32'h10000, 512);
    pulseStart(32'h10000, 512);
    fork
      applyStimulus(1'b0, 1 << 30);
      begin
        guard = 0;
        while (aw_seen < 4 && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
        repeat (200) @(negedge clk);
        checkOutput("jobC_stall_aw", 512'(aw_seen), 512'(4));
        checkOutput("jobC_stall_bready", 512'(axi.bready), 512'(1));
        b_hold = 1'b0;
      end
    join
    waitDone("jobC", 3, 8);

    $display("[TB] job D: 300 beats with random gaps");
    rand_mode = 1'b1;
    prepJob(32'h20000, 300);
    pulseStart(32'h20000, 300);
    applyStimulus(1'b1, 1 << 30);
    waitDone("jobD", 4, 5);
    rand_mode = 1'b0;

    $display("[TB] job E: error response on second burst");
    err_burst = 1;
    prepJob(32'h30000, 128);
    pulseStart(32'h30000, 128);
    applyStimulus(1'b0, 1 << 30);
    waitDone("jobE", 5, 2);
    checkOutput("jobE_err_sticky", 512'(job_err), 512'(1));
    err_burst = -1;

    $display("[TB] job F: zero beats");
    prepJob(32'h0, 0);
    pulseStart(32'h0, 0);
    @(negedge clk);
    checkOutput("jobF_done_pulse", 512'(job_done), 512'(1));
    checkOutput("jobF_busy", 512'(job_busy), 512'(0));
    checkOutput("jobF_err_cleared", 512'(job_err), 512'(0));
    waitDone("jobF", 6, 0);

    $display("[TB] job G: reset in the middle of a job");
    rand_mode = 1'b1;
    prepJob(32'h50000, 256);
    pulseStart(32'h50000, 256);
    applyStimulus(1'b0, 296);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    job_id++;
    @(negedge clk);
    checkOutput("midrst_busy", 512'(job_busy), 512'(0));
    checkOutput("midrst_awvalid", 512'(axi.awvalid), 512'(0));
    checkOutput("midrst_wvalid", 512'(axi.wvalid), 512'(0));
    checkOutput("midrst_awaddr", 512'(axi.awaddr), 512'(0));
    aw_exp_addr.delete();
    aw_exp_len.delete();
    w_exp_data.delete();
    w_exp_last.delete();
    done_exp.delete();
    in_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_mode = 1'b0;

    $display("[TB] job H: clean job after reset");
    prepJob(32'h60000, 64);
    pulseStart(32'h60000, 64);
    applyStimulus(1'b0, 1 << 30);
    waitDone("jobH", 7, 1);
    checkOutput("jobH_err", 512'(job_err), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
